// File: rtl/vga_port_ctrl.sv
// rtl/vga_port_ctrl.sv - host register engine for the text VGA controller
module vga_port_ctrl #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_rst_h,
    input  logic [7:0]        i_cmd,
    input  logic [7:0]        i_port,
    input  logic              i_rl_wh,
    input  logic              i_cs_h,
    output logic [7:0]        o_port,
    output logic              o_ready_h,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [7:0]        o_vram_data,
    output logic              o_vram_we_h,
    output logic [ADDR_W-1:0] o_cram_addr,
    output logic [7:0]        o_cram_data,
    output logic              o_cram_we_h,
    output logic [ADDR_W-1:0] o_cursor_cur_addr,
    output logic              o_cursor_enable_h
);

    localparam int                CELLS     = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);
    localparam logic [7:0]        COLS_B    = 8'(COLS);
    localparam logic [7:0]        ROWS_B    = 8'(ROWS);
    localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
    localparam logic [7:0]        LAST_ROW  = 8'(ROWS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_FILL = 2'd3;

    localparam logic [7:0] REG_STATUS  = 8'd0;
    localparam logic [7:0] REG_DATA    = 8'd1;
    localparam logic [7:0] REG_CUR_X   = 8'd2;
    localparam logic [7:0] REG_CUR_Y   = 8'd3;
    localparam logic [7:0] REG_CONTROL = 8'd4;
    localparam logic [7:0] REG_COLOR   = 8'd5;
    localparam logic [7:0] REG_FILL    = 8'd6;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;

    logic [1:0]        r_st;
    logic [7:0]        r_cmd;
    logic [7:0]        r_data;
    logic              r_wr;
    logic [7:0]        r_x;
    logic [7:0]        r_y;
    logic [7:0]        r_ctrl;
    logic [7:0]        r_color;
    logic              r_err;
    logic [7:0]        r_port;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_vdata;
    logic [7:0]        r_cdata;
    logic              r_we;

    logic [15:0]       w_cur_lin;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_exec;
    logic              w_is_ctl;
    logic              w_bad_wr;
    logic              w_busy_req;
    logic              w_stat_rd;
    logic              w_err_set;
    logic [7:0]        w_rd_data;

    // Geometry is limited to 255x255, so the linear address always fits in 16 bits.
    assign w_cur_lin  = 16'(r_y) * 16'(COLS) + 16'(r_x);
    assign w_cur_addr = w_cur_lin[ADDR_W-1:0];

    assign w_exec     = (r_st == ST_EXEC);
    assign w_is_ctl   = r_ctrl[1] && (r_data == CH_CR || r_data == CH_LF || r_data == CH_BS);
    assign w_bad_wr   = w_exec && r_wr &&
                        ((r_cmd == REG_CUR_X && r_data >= COLS_B) ||
                         (r_cmd == REG_CUR_Y && r_data >= ROWS_B) ||
                         (r_cmd > REG_FILL));
    assign w_busy_req = i_cs_h && (r_st != ST_IDLE);
    assign w_stat_rd  = w_exec && !r_wr && (r_cmd == REG_STATUS);
    assign w_err_set  = w_bad_wr || w_busy_req;

    always_comb begin
        w_rd_data = 8'hEE;
        case (r_cmd)
            REG_STATUS:  w_rd_data = {3'b101, 2'b00, 1'b0, r_err, 1'b1};
            REG_DATA:    w_rd_data = 8'hFF;
            REG_CUR_X:   w_rd_data = r_x;
            REG_CUR_Y:   w_rd_data = r_y;
            REG_CONTROL: w_rd_data = r_ctrl;
            REG_COLOR:   w_rd_data = r_color;
            default:     w_rd_data = 8'hEE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst_h) begin
        if (i_rst_h) begin
            r_st    <= ST_IDLE;
            r_cmd   <= 8'h00;
            r_data  <= 8'h00;
            r_wr    <= 1'b0;
            r_x     <= 8'h00;
            r_y     <= 8'h00;
            r_ctrl  <= 8'h01;
            r_color <= 8'h07;
            r_err   <= 1'b0;
            r_port  <= 8'h00;
            r_addr  <= '0;
            r_vdata <= 8'h00;
            r_cdata <= 8'h00;
            r_we    <= 1'b0;
        end else begin
            // A new error in the same cycle as a STATUS read-clear takes priority.
            r_err <= w_err_set | (r_err & ~w_stat_rd);
            case (r_st)
                ST_IDLE: begin
                    if (i_cs_h) begin
                        r_cmd  <= i_cmd;
                        r_data <= i_port;
                        r_wr   <= i_rl_wh;
                        r_st   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_st <= ST_IDLE;
                    if (!r_wr) begin
                        r_port <= w_rd_data;
                    end else begin
                        case (r_cmd)
                            REG_DATA: begin
                                if (w_is_ctl) begin
                                    if (r_data == CH_CR) begin
                                        r_x <= 8'h00;
                                    end else if (r_data == CH_LF) begin
                                        r_y <= (r_y == LAST_ROW) ? 8'h00 : r_y + 8'd1;
                                    end else if (r_x != 8'h00) begin
                                        r_x <= r_x - 8'd1;
                                    end else if (r_y != 8'h00) begin
                                        r_x <= LAST_COL;
                                        r_y <= r_y - 8'd1;
                                    end
                                end else begin
                                    r_addr  <= w_cur_addr;
                                    r_vdata <= r_data;
                                    r_cdata <= r_color;
                                    r_we    <= 1'b1;
                                    r_st    <= ST_STEP;
                                end
                            end
                            REG_CUR_X: begin
                                if (r_data < COLS_B) r_x <= r_data;
                            end
                            REG_CUR_Y: begin
                                if (r_data < ROWS_B) r_y <= r_data;
                            end
                            REG_CONTROL: r_ctrl  <= r_data;
                            REG_COLOR:   r_color <= r_data;
                            REG_FILL: begin
                                r_addr  <= '0;
                                r_vdata <= r_data;
                                r_cdata <= r_color;
                                r_we    <= 1'b1;
                                r_st    <= ST_FILL;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STEP: begin
                    r_we <= 1'b0;
                    r_st <= ST_IDLE;
                    if (r_x == LAST_COL) begin
                        r_x <= 8'h00;
                        r_y <= (r_y == LAST_ROW) ? 8'h00 : r_y + 8'd1;
                    end else begin
                        r_x <= r_x + 8'd1;
                    end
                end
                ST_FILL: begin
                    if (r_addr == LAST_CELL) begin
                        r_we <= 1'b0;
                        r_x  <= 8'h00;
                        r_y  <= 8'h00;
                        r_st <= ST_IDLE;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

    assign o_port            = r_port;
    assign o_ready_h         = (r_st == ST_IDLE);
    assign o_vram_addr       = r_addr;
    assign o_vram_data       = r_vdata;
    assign o_vram_we_h       = r_we;
    assign o_cram_addr       = r_addr;
    assign o_cram_data       = r_cdata;
    assign o_cram_we_h       = r_we;
    assign o_cursor_cur_addr = w_cur_addr;
    assign o_cursor_enable_h = r_ctrl[0];

endmodule

// File: tb/tb_vga_port_ctrl.sv
// tb/tb_vga_port_ctrl.sv - scoreboard bench for vga_port_ctrl
module tb_vga_port_ctrl;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int ADDR_W = 11;
    localparam int CELLS  = COLS * ROWS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        i_cmd = 8'h00;
    logic [7:0]        i_port = 8'h00;
    logic              i_rl_wh = 1'b0;
    logic              i_cs_h = 1'b0;
    logic [7:0]        o_port;
    logic              o_ready_h;
    logic [ADDR_W-1:0] o_vram_addr;
    logic [7:0]        o_vram_data;
    logic              o_vram_we_h;
    logic [ADDR_W-1:0] o_cram_addr;
    logic [7:0]        o_cram_data;
    logic              o_cram_we_h;
    logic [ADDR_W-1:0] o_cursor_cur_addr;
    logic              o_cursor_enable_h;

    vga_port_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .i_clk(clk), .i_rst_h(rst), .i_cmd(i_cmd), .i_port(i_port),
        .i_rl_wh(i_rl_wh), .i_cs_h(i_cs_h), .o_port(o_port), .o_ready_h(o_ready_h),
        .o_vram_addr(o_vram_addr), .o_vram_data(o_vram_data), .o_vram_we_h(o_vram_we_h),
        .o_cram_addr(o_cram_addr), .o_cram_data(o_cram_data), .o_cram_we_h(o_cram_we_h),
        .o_cursor_cur_addr(o_cursor_cur_addr), .o_cursor_enable_h(o_cursor_enable_h)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: cursor as plain integers, cell writes as {addr, glyph, colour}.
    int         m_x, m_y;
    logic [7:0] m_ctrl, m_color;
    logic       m_err;
    logic [31:0] wq[$];
    logic [25:0] tq[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_ctrl = 8'h01; m_color = 8'h07; m_err = 1'b0;
    endtask

    task automatic model_op(input logic [7:0] cmd, input logic [7:0] data, input logic wr,
                            output logic is_rd, output logic [7:0] rd);
        int lin;
        is_rd = !wr;
        rd = 8'h00;
        if (!wr) begin
            case (cmd)
                8'd0: begin rd = m_err ? 8'hA3 : 8'hA1; m_err = 1'b0; end
                8'd1: rd = 8'hFF;
                8'd2: rd = 8'(m_x);
                8'd3: rd = 8'(m_y);
                8'd4: rd = m_ctrl;
                8'd5: rd = m_color;
                default: rd = 8'hEE;
            endcase
        end else begin
            case (cmd)
                8'd0: ;
                8'd1: begin
                    lin = m_y * COLS + m_x;
                    if (m_ctrl[1] && data == 8'h0D) m_x = 0;
                    else if (m_ctrl[1] && data == 8'h0A) m_y = (m_y + 1) % ROWS;
                    else if (m_ctrl[1] && data == 8'h08) begin
                        if (lin > 0) lin = lin - 1;
                        m_x = lin % COLS; m_y = lin / COLS;
                    end else begin
                        wq.push_back({16'(lin), data, m_color});
                        lin = (lin + 1) % CELLS;
                        m_x = lin % COLS; m_y = lin / COLS;
                    end
                end
                8'd2: if (int'(data) < COLS) m_x = int'(data); else m_err = 1'b1;
                8'd3: if (int'(data) < ROWS) m_y = int'(data); else m_err = 1'b1;
                8'd4: m_ctrl = data;
                8'd5: m_color = data;
                8'd6: begin
                    for (int a = 0; a < CELLS; a++) wq.push_back({16'(a), data, m_color});
                    m_x = 0; m_y = 0;
                end
                default: m_err = 1'b1;
            endcase
        end
    endtask

    task automatic issue(input logic [7:0] cmd, input logic [7:0] data, input logic wr);
        int n;
        logic is_rd;
        logic [7:0] rd;
        n = 0;
        @(negedge clk);
        while (!o_ready_h && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready_h) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        model_op(cmd, data, wr, is_rd, rd);
        tq.push_back({is_rd, rd, m_ctrl[0], 16'(m_y * COLS + m_x)});
        i_cmd = cmd; i_port = data; i_rl_wh = wr; i_cs_h = 1'b1;
        @(posedge clk);
        #1 i_cs_h = 1'b0;
    endtask

    // Strobe while the engine is known to be busy: dropped, flags an error.
    task automatic poke(input logic [7:0] cmd);
        @(negedge clk);
        i_cmd = cmd; i_port = 8'h55; i_rl_wh = 1'b0; i_cs_h = 1'b1;
        m_err = 1'b1;
        @(posedge clk);
        #1 i_cs_h = 1'b0;
    endtask

    initial begin : monitor
        logic        prev;
        logic [31:0] e;
        logic [25:0] t;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = o_ready_h;
            end else begin
                if (o_vram_we_h) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_we", {16'(o_vram_addr), o_vram_data, o_cram_data}, 32'hFFFFFFFF);
                    end else begin
                        e = wq.pop_front();
                        chk("wr_cell", {16'(o_vram_addr), o_vram_data, o_cram_data}, e);
                        chk("cram_addr", 32'(o_cram_addr), 32'(e[31:16]));
                        chk("cram_we", 32'(o_cram_we_h), 32'd1);
                    end
                end
                if (o_ready_h && !prev) begin
                    if (tq.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        t = tq.pop_front();
                        chk("cursor_addr", 32'(o_cursor_cur_addr), 32'(t[15:0]));
                        chk("cursor_en", 32'(o_cursor_enable_h), 32'(t[16]));
                        if (t[25]) chk("rd_data", 32'(o_port), 32'(t[24:17]));
                    end
                end
                prev = o_ready_h;
            end
        end
    end

    initial begin : watchdog
        #700000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int r;
        int n;
        logic [7:0] c;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(o_ready_h), 32'd1);
        chk("rst_port", 32'(o_port), 32'd0);
        chk("rst_we", {31'd0, o_vram_we_h}, 32'd0);
        chk("rst_addr", 32'(o_vram_addr), 32'd0);
        chk("rst_data", {16'd0, o_vram_data, o_cram_data}, 32'd0);
        chk("rst_cursor", 32'(o_cursor_cur_addr), 32'd0);
        chk("rst_cur_en", 32'(o_cursor_enable_h), 32'd1);
        issue(8'd4, 8'h00, 1'b0);
        issue(8'd5, 8'h00, 1'b0);
        issue(8'd0, 8'h00, 1'b0);

        issue(8'd5, 8'h1E, 1'b1);
        issue(8'd2, 8'd5, 1'b1);
        issue(8'd3, 8'd2, 1'b1);
        issue(8'd1, 8'h41, 1'b1);
        issue(8'd2, 8'd79, 1'b1);
        issue(8'd3, 8'd24, 1'b1);
        issue(8'd1, 8'h42, 1'b1);

        issue(8'd4, 8'h03, 1'b1);
        issue(8'd2, 8'd10, 1'b1);
        issue(8'd3, 8'd3, 1'b1);
        issue(8'd1, 8'h0D, 1'b1);
        issue(8'd1, 8'h0A, 1'b1);
        issue(8'd1, 8'h08, 1'b1);
        issue(8'd2, 8'h00, 1'b0);
        issue(8'd3, 8'h00, 1'b0);
        issue(8'd4, 8'h01, 1'b1);
        issue(8'd1, 8'h0D, 1'b1);

        issue(8'd6, 8'h20, 1'b1);
        repeat (10) @(negedge clk);
        poke(8'd0);
        issue(8'd0, 8'h00, 1'b0);
        issue(8'd0, 8'h00, 1'b0);

        issue(8'd2, 8'd80, 1'b1);
        issue(8'd3, 8'd25, 1'b1);
        issue(8'd0, 8'h00, 1'b0);
        issue(8'd9, 8'h12, 1'b1);
        issue(8'd9, 8'h00, 1'b0);
        issue(8'd0, 8'h00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                c = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 2) == 0) c = (r % 3 == 0) ? 8'h0D : ((r % 3 == 1) ? 8'h0A : 8'h08);
                issue(8'd1, c, 1'b1);
            end else if (r < 50) issue(8'd2, 8'($urandom_range(0, COLS + 5)), 1'b1);
            else if (r < 58) issue(8'd3, 8'($urandom_range(0, ROWS + 3)), 1'b1);
            else if (r < 64) issue(8'd4, 8'($urandom_range(0, 255)), 1'b1);
            else if (r < 70) issue(8'd5, 8'($urandom_range(0, 255)), 1'b1);
            else if (r < 74) issue(8'($urandom_range(7, 255)), 8'($urandom_range(0, 255)), 1'b1);
            else begin
                c = 8'($urandom_range(0, 9));
                if (c == 8'd6) c = 8'd7;
                issue(c, 8'h00, 1'b0);
            end
        end

        issue(8'd4, 8'h00, 1'b1);
        issue(8'd5, 8'h5A, 1'b1);
        issue(8'd6, 8'h2E, 1'b1);
        n = 0;
        @(negedge clk);
        while (!(o_vram_we_h && o_vram_addr == 11'd700) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("fill_reach_700", 32'(o_vram_addr), 32'd700);
        #2 rst = 1'b1;
        #1;
        chk("arst_we", {31'd0, o_vram_we_h}, 32'd0);
        chk("arst_ready", 32'(o_ready_h), 32'd1);
        chk("arst_addr", 32'(o_vram_addr), 32'd0);
        chk("arst_cur_en", 32'(o_cursor_enable_h), 32'd1);
        wq.delete();
        tq.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(8'd4, 8'h00, 1'b0);
        issue(8'd5, 8'h00, 1'b0);
        issue(8'd0, 8'h00, 1'b0);
        issue(8'd2, 8'h00, 1'b0);
        issue(8'd1, 8'h33, 1'b1);

        n = 0;
        while (!o_ready_h && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("wq_drained", 32'(wq.size()), 32'd0);
        chk("tq_drained", 32'(tq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
